router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_pkg.sv | 25 ++
 rtl/router_fsm.sv | 178 +++++++++++++++++
 tb/tb_router_fsm.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the packet router control path.
//   - state_t      : router FSM state encoding
//   - ADDR_*       : header address constants carried on data_in[1:0]
// ---------------------------------------------------------------------------
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ADDR_0       = 2'b00;
    localparam logic [1:0] ADDR_1       = 2'b01;
    localparam logic [1:0] ADDR_2       = 2'b10;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_fsm.sv
// ---------------------------------------------------------------------------
// router_fsm
//   Control FSM of a 3-port packet router. Decodes the header address,
//   sequences header/payload/parity loads into the selected output FIFO,
//   stalls on FIFO full, and waits for a non-empty destination to drain
//   (optionally abandoning the packet after WAIT_TIMEOUT cycles).
//
// Parameters
//   WAIT_TIMEOUT    : max cycles spent in WAIT_TILL_EMPTY before the packet
//                     is dropped (0 = wait forever)
// Ports
//   clock, resetn             : clock (rising edge), async active-low reset
//   pkt_valid, data_in[1:0]   : source packet-valid and header address
//   fifo_full                 : selected output FIFO full
//   fifo_empty_0..2           : per-port FIFO empty
//   soft_reset_0..2           : per-port soft reset (from synchronizer)
//   parity_done, low_packet_valid : register-block status
//   detect_add, lfd_state, ld_state, laf_state, full_state : state decodes
//   write_enb_reg             : FIFO write enable
//   rst_int_reg               : clears register-block parity tracking
//   busy                      : back-pressure to source
//   drop_pkt                  : one-cycle pulse when a waiting packet is dropped
//
// All outputs are registered from the next-state value, so they present as
// pure decodes of the current state with no combinational input paths.
// ---------------------------------------------------------------------------
module router_fsm
    import router_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy,
    output logic       drop_pkt
);

    // Counter wide enough to hold WAIT_TIMEOUT; at least one bit.
    localparam int CW = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    dest;
    logic [CW-1:0] wait_cnt;
    logic          drop_nxt;

    logic          empty_dest;   // fifo_empty of the latched destination
    logic          srst_dest;    // soft_reset of the latched destination
    logic          empty_addr;   // fifo_empty of the incoming header address
    logic          timeout_hit;

    always_comb begin
        empty_dest = fifo_empty_0;
        srst_dest  = soft_reset_0;
        case (dest)
            ADDR_1: begin
                empty_dest = fifo_empty_1;
                srst_dest  = soft_reset_1;
            end
            ADDR_2: begin
                empty_dest = fifo_empty_2;
                srst_dest  = soft_reset_2;
            end
            default: ;
        endcase
    end

    always_comb begin
        empty_addr = fifo_empty_0;
        case (data_in)
            ADDR_1:  empty_addr = fifo_empty_1;
            ADDR_2:  empty_addr = fifo_empty_2;
            default: ;
        endcase
    end

    // wait_cnt is 0 in the first WAIT cycle, so the Nth cycle sees N-1.
    assign timeout_hit = (WAIT_TIMEOUT > 0) && (int'(wait_cnt) + 1 >= WAIT_TIMEOUT);

    always_comb begin
        state_nxt = state;
        drop_nxt  = 1'b0;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != ADDR_INVALID)
                    state_nxt = empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_dest) begin
                    state_nxt = LOAD_FIRST_DATA;
                end else if (timeout_hit) begin
                    state_nxt = DECODE_ADDRESS;
                    drop_nxt  = 1'b1;
                end
            end
            LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_nxt = FIFO_FULL_STATE;
                else if (!pkt_valid) state_nxt = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)           state_nxt = DECODE_ADDRESS;
                else if (low_packet_valid) state_nxt = LOAD_PARITY;
                else                       state_nxt = LOAD_DATA;
            end
            LOAD_PARITY:        state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            state_nxt = DECODE_ADDRESS;
        endcase
        // Soft reset of the active destination aborts the packet from anywhere
        // except address decode, and suppresses a coincident drop pulse.
        if (state != DECODE_ADDRESS && srst_dest) begin
            state_nxt = DECODE_ADDRESS;
            drop_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state         <= DECODE_ADDRESS;
            dest          <= ADDR_0;
            wait_cnt      <= '0;
            drop_pkt      <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            write_enb_reg <= 1'b0;
            rst_int_reg   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state    <= state_nxt;
            drop_pkt <= drop_nxt;

            if (state == DECODE_ADDRESS && state_nxt != DECODE_ADDRESS)
                dest <= data_in;

            if (state_nxt == WAIT_TILL_EMPTY && state != WAIT_TILL_EMPTY)
                wait_cnt <= '0;
            else if (state == WAIT_TILL_EMPTY && wait_cnt != CNT_MAX)
                wait_cnt <= wait_cnt + 1'b1;

            detect_add    <= (state_nxt == DECODE_ADDRESS);
            lfd_state     <= (state_nxt == LOAD_FIRST_DATA);
            ld_state      <= (state_nxt == LOAD_DATA);
            laf_state     <= (state_nxt == LOAD_AFTER_FULL);
            full_state    <= (state_nxt == FIFO_FULL_STATE);
            rst_int_reg   <= (state_nxt == CHECK_PARITY_ERROR);
            write_enb_reg <= (state_nxt == LOAD_DATA) || (state_nxt == LOAD_AFTER_FULL) ||
                             (state_nxt == LOAD_PARITY);
            busy          <= !((state_nxt == DECODE_ADDRESS) || (state_nxt == LOAD_DATA));
        end
    end

endmodule

// File: tb/tb_router_fsm.sv
// ---------------------------------------------------------------------------
// tb_router_fsm
//   Two router_fsm instances share all inputs: one with the default
//   WAIT_TIMEOUT (never drop) and one with WAIT_TIMEOUT=5. A packet-level
//   model tracks each instance and is compared every cycle; directed
//   scenarios also check hand-written output vectors.
//   Output vector order: {detect,lfd,ld,laf,full,rst_int,we,busy,drop}.
// ---------------------------------------------------------------------------
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic [2:0] empty;
    logic [2:0] srst;
    logic       parity_done;
    logic       low_packet_valid;
    wire  [8:0] o0;
    wire  [8:0] o5;

    int npass = 0;
    int ntotal = 0;

    always #5 clock = ~clock;

    router_fsm u_dut0 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]),
        .fifo_empty_2(empty[2]), .soft_reset_0(srst[0]), .soft_reset_1(srst[1]),
        .soft_reset_2(srst[2]), .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(o0[8]), .lfd_state(o0[7]), .ld_state(o0[6]), .laf_state(o0[5]),
        .full_state(o0[4]), .rst_int_reg(o0[3]), .write_enb_reg(o0[2]), .busy(o0[1]),
        .drop_pkt(o0[0])
    );

    router_fsm #(.WAIT_TIMEOUT(5)) u_dut5 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]),
        .fifo_empty_2(empty[2]), .soft_reset_0(srst[0]), .soft_reset_1(srst[1]),
        .soft_reset_2(srst[2]), .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(o5[8]), .lfd_state(o5[7]), .ld_state(o5[6]), .laf_state(o5[5]),
        .full_state(o5[4]), .rst_int_reg(o5[3]), .write_enb_reg(o5[2]), .busy(o5[1]),
        .drop_pkt(o5[0])
    );

    // Hand-written output vectors per phase.
    localparam logic [8:0] O_DA   = 9'b100000000;
    localparam logic [8:0] O_LFD  = 9'b010000010;
    localparam logic [8:0] O_LD   = 9'b001000100;
    localparam logic [8:0] O_WT   = 9'b000000010;
    localparam logic [8:0] O_FULL = 9'b000010010;
    localparam logic [8:0] O_LAF  = 9'b000100110;
    localparam logic [8:0] O_LP   = 9'b000000110;
    localparam logic [8:0] O_CPE  = 9'b000001010;
    localparam logic [8:0] O_DROP = 9'b100000001;

    // ---------------- packet-level model ----------------
    typedef enum int {M_DA, M_LFD, M_LD, M_WAIT, M_FULL, M_LAF, M_LP, M_CPE} mst_t;
    typedef struct packed {
        mst_t       st;
        logic [1:0] dest;
        int         waited;   // WAIT cycles spent so far, including the current one
        logic       drop;
    } mdl_t;

    localparam mdl_t MRST = '{st: M_DA, dest: 2'd0, waited: 0, drop: 1'b0};

    mdl_t m0 = MRST;
    mdl_t m5 = MRST;

    function automatic mdl_t mnext(input mdl_t c, input int tmo);
        mdl_t n;
        n = c;
        n.drop = 1'b0;
        if (c.st != M_DA && srst[c.dest]) begin
            n.st = M_DA;
            return n;
        end
        case (c.st)
            M_DA: if (pkt_valid && data_in != 2'd3) begin
                n.dest   = data_in;
                n.st     = empty[data_in] ? M_LFD : M_WAIT;
                n.waited = 1;
            end
            M_WAIT: begin
                if (empty[c.dest])                   n.st = M_LFD;
                else if (tmo > 0 && c.waited >= tmo) begin n.st = M_DA; n.drop = 1'b1; end
                else                                 n.waited = c.waited + 1;
            end
            M_LFD:  n.st = M_LD;
            M_LD:   if (fifo_full) n.st = M_FULL; else if (!pkt_valid) n.st = M_LP;
            M_FULL: if (!fifo_full) n.st = M_LAF;
            M_LAF:  n.st = parity_done ? M_DA : (low_packet_valid ? M_LP : M_LD);
            M_LP:   n.st = M_CPE;
            M_CPE:  n.st = fifo_full ? M_FULL : M_DA;
            default: n.st = M_DA;
        endcase
        return n;
    endfunction

    function automatic logic [8:0] exp_out(input mdl_t c);
        return {c.st == M_DA, c.st == M_LFD, c.st == M_LD, c.st == M_LAF, c.st == M_FULL,
                c.st == M_CPE, (c.st == M_LD || c.st == M_LAF || c.st == M_LP),
                !(c.st == M_DA || c.st == M_LD), c.drop};
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m0 <= MRST;
            m5 <= MRST;
        end else begin
            m0 <= mnext(m0, 0);
            m5 <= mnext(m5, 5);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic lit(input string nm, input logic [8:0] e0, input logic [8:0] e5);
        chk({nm, "/t0"}, {23'd0, o0}, {23'd0, e0});
        chk({nm, "/t5"}, {23'd0, o5}, {23'd0, e5});
    endtask

    logic run_cmp = 1'b0;
    always @(negedge clock) begin
        if (run_cmp) begin
            chk("model_t0", {23'd0, o0}, {23'd0, exp_out(m0)});
            chk("model_t5", {23'd0, o5}, {23'd0, exp_out(m5)});
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    int we_cnt;

    initial begin
        resetn = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        empty = 3'b111; srst = 3'b000; parity_done = 1'b0; low_packet_valid = 1'b0;
        #1 resetn = 1'b0;
        run_cmp = 1'b1;
        step(); step();
        lit("reset", O_DA, O_DA);
        resetn = 1'b1;

        // Addr 1, three payload cycles, then pkt_valid drops.
        pkt_valid = 1'b1; data_in = 2'd1;
        we_cnt = 0;
        step(); lit("s1_lfd", O_LFD, O_LFD); we_cnt += int'(o5[2]);
        step(); lit("s1_ld1", O_LD, O_LD);   we_cnt += int'(o5[2]);
        step(); lit("s1_ld2", O_LD, O_LD);   we_cnt += int'(o5[2]);
        step(); lit("s1_ld3", O_LD, O_LD);   we_cnt += int'(o5[2]);
        pkt_valid = 1'b0;
        step(); lit("s1_lp", O_LP, O_LP);    we_cnt += int'(o5[2]);
        step(); lit("s1_cpe", O_CPE, O_CPE); we_cnt += int'(o5[2]);
        step(); lit("s1_da", O_DA, O_DA);    we_cnt += int'(o5[2]);
        // write enable spans the three LD cycles plus LP
        chk("s1_we_cycles", we_cnt, 4);

        // Addr 2 with destination FIFO not empty for four cycles.
        pkt_valid = 1'b1; data_in = 2'd2; empty[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); lit("s2_wait", O_WT, O_WT);
        end
        empty[2] = 1'b1;
        step(); lit("s2_lfd", O_LFD, O_LFD);

        // FIFO full for three cycles in LD, then LAF -> LP -> CPE -> FULL -> LAF -> DA.
        step(); lit("s3_ld", O_LD, O_LD);
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); lit("s3_full", O_FULL, O_FULL);
        end
        fifo_full = 1'b0; low_packet_valid = 1'b1;
        step(); lit("s3_laf", O_LAF, O_LAF);
        step(); lit("s3_lp", O_LP, O_LP);
        low_packet_valid = 1'b0; pkt_valid = 1'b0;
        step(); lit("s3_cpe", O_CPE, O_CPE);
        fifo_full = 1'b1;
        step(); lit("s3_cpe_full", O_FULL, O_FULL);
        fifo_full = 1'b0;
        step(); lit("s3_laf2", O_LAF, O_LAF);
        parity_done = 1'b1;
        step(); lit("s3_done", O_DA, O_DA);
        parity_done = 1'b0;

        // Invalid address is ignored.
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 3; i++) begin
            step(); lit("s4_addr3", O_DA, O_DA);
        end

        // Soft reset: only the latched destination's soft reset aborts.
        data_in = 2'd0;
        step(); lit("s5_lfd", O_LFD, O_LFD);
        step(); lit("s5_ld", O_LD, O_LD);
        srst = 3'b010;
        step(); lit("s5_srst1", O_LD, O_LD);
        srst = 3'b001;
        step(); lit("s5_srst0", O_DA, O_DA);
        srst = 3'b000; pkt_valid = 1'b0;
        step(); lit("s5_idle", O_DA, O_DA);

        // Wait timeout: only the WAIT_TIMEOUT=5 instance drops the packet.
        pkt_valid = 1'b1; data_in = 2'd0; empty[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(); lit("s6_wait", O_WT, O_WT);
        end
        pkt_valid = 1'b0;
        step(); lit("s6_drop", O_WT, O_DROP);
        step(); lit("s6_after", O_WT, O_DA);
        empty[0] = 1'b1;
        step(); lit("s6_lfd", O_LFD, O_DA);
        step(); lit("s6_ld", O_LD, O_DA);
        step(); lit("s6_lp", O_LP, O_DA);
        step(); lit("s6_cpe", O_CPE, O_DA);
        step(); lit("s6_da", O_DA, O_DA);

        // Asynchronous reset in the middle of a packet.
        pkt_valid = 1'b1; data_in = 2'd1;
        step(); lit("s7_lfd", O_LFD, O_LFD);
        step(); lit("s7_ld", O_LD, O_LD);
        #1 resetn = 1'b0;
        #1 lit("s7_async", O_DA, O_DA);
        step(); lit("s7_hold", O_DA, O_DA);
        resetn = 1'b1; pkt_valid = 1'b0;
        step(); lit("s7_resume", O_DA, O_DA);
        step();

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
